// File: rtl/bus_sram_slave_pkg.sv
// Shared bus definitions: slave state encoding and burst-count width.
package bus_sram_slave_pkg;

  localparam int BURST_COUNT_WIDTH = 9;

  typedef logic [BURST_COUNT_WIDTH-1:0] burstCount_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_ADDR,
    READ_DATA,
    END,
    ERROR
  } busState_t;

endpackage

// File: rtl/sram_be_1rw.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables, 1-cycle read.
module sram_be_1rw #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock_i,
  input  logic                  writeEnable_i,
  input  logic                  readEnable_i,
  input  logic [3:0]            byteEnables_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [31:0]           writeData_i,
  output logic [31:0]           readData_o
);

  logic [31:0] memQ [2**ADDR_WIDTH];
  logic [31:0] readDataQ;

  // No reset: contents survive reset and start undefined.
  always_ff @(posedge clock_i) begin
    if (writeEnable_i) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEnables_i[b]) begin
          memQ[address_i][8*b +: 8] <= writeData_i[8*b +: 8];
        end
      end
    end
    if (readEnable_i) begin
      readDataQ <= memQ[address_i];
    end
  end

  assign readData_o = readDataQ;

endmodule

// File: rtl/bus_sram_slave.sv
// Burst-capable SRAM slave on a wired-OR bus; outputs are zero unless driving.
module bus_sram_slave
  import bus_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS     = 32'h5000_0000,
  parameter int          NR_OF_WORDS_LOG2 = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        readNotWriteIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut
);

  localparam int          AW          = NR_OF_WORDS_LOG2;
  localparam logic [32:0] SPAN_BYTES  = 33'd4 << AW;
  localparam logic [31:0] NR_OF_WORDS = 32'd1 << AW;

  busState_t     stateQ, stateD;
  logic [AW-1:0] addressQ, addressD;
  burstCount_t   countQ, countD;

  logic [31:0]   offset;
  logic [AW-1:0] startWord;
  logic [31:0]   lastWord;
  logic          selected;
  logic          overrun;
  logic          abort;
  logic          ramWrite;
  logic          ramRead;
  logic [31:0]   ramReadData;

  // An address below the base wraps to a huge offset and is therefore unselected.
  assign offset    = addressDataIn - BASE_ADDRESS;
  assign selected  = {1'b0, offset} < SPAN_BYTES;
  assign startWord = offset[AW+1:2];
  assign lastWord  = 32'(startWord) + 32'(burstSizeIn);
  assign overrun   = lastWord >= NR_OF_WORDS;
  assign abort     = busErrorIn || endTransactionIn;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ   <= IDLE;
      addressQ <= '0;
      countQ   <= '0;
    end else begin
      stateQ   <= stateD;
      addressQ <= addressD;
      countQ   <= countD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    addressD = addressQ;
    countD   = countQ;
    ramWrite = 1'b0;
    ramRead  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (beginTransactionIn && selected) begin
          addressD = startWord;
          countD   = burstCount_t'(burstSizeIn) + burstCount_t'(1);
          if (overrun) begin
            stateD = ERROR;
          end else if (readNotWriteIn) begin
            stateD = READ_ADDR;
          end else begin
            stateD = WRITE;
          end
        end
      end
      WRITE: begin
        // A data beat coinciding with the master's end is still stored.
        if (dataValidIn && (countQ != '0) && !busErrorIn) begin
          ramWrite = 1'b1;
          addressD = addressQ + 1'b1;
          countD   = countQ - 1'b1;
        end
        if (abort) begin
          stateD = IDLE;
        end
      end
      READ_ADDR: begin
        ramRead  = 1'b1;
        addressD = addressQ + 1'b1;
        stateD   = abort ? IDLE : READ_DATA;
      end
      READ_DATA: begin
        // The word on the bus now was fetched last cycle; prefetch the next.
        countD = countQ - 1'b1;
        if (countQ == burstCount_t'(1)) begin
          stateD = END;
        end else begin
          ramRead  = 1'b1;
          addressD = addressQ + 1'b1;
        end
        if (abort) begin
          stateD = IDLE;
        end
      end
      END:     stateD = IDLE;
      ERROR:   stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  assign dataValidOut      = (stateQ == READ_DATA);
  assign addressDataOut    = dataValidOut ? ramReadData : 32'd0;
  assign endTransactionOut = (stateQ == END) || (stateQ == ERROR);
  assign busErrorOut       = (stateQ == ERROR);

  sram_be_1rw #(
    .ADDR_WIDTH(AW)
  ) u_sram (
    .clock_i      (clock),
    .writeEnable_i(ramWrite),
    .readEnable_i (ramRead),
    .byteEnables_i(byteEnablesIn),
    .address_i    (addressQ),
    .writeData_i  (addressDataIn),
    .readData_o   (ramReadData)
  );

endmodule

// File: tb/tb_bus_sram_slave.sv
// Self-checking bench for bus_sram_slave: directed scenarios plus randomized transactions
// checked cycle by cycle against a word-array memory model.
module tb_bus_sram_slave;

  localparam logic [31:0] BASE  = 32'h5000_0000;
  localparam int          WORDS = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic [3:0]  byteEnablesIn;
  logic [7:0]  burstSizeIn;
  logic        readNotWriteIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] model  [WORDS];
  logic [31:0] wrData [256];
  logic [3:0]  wrBe   [256];
  logic [31:0] rdWords [$];

  always #5 clock = ~clock;

  bus_sram_slave dut (
    .clock            (clock),
    .reset            (reset),
    .beginTransactionIn(beginTransactionIn),
    .addressDataIn    (addressDataIn),
    .byteEnablesIn    (byteEnablesIn),
    .burstSizeIn      (burstSizeIn),
    .readNotWriteIn   (readNotWriteIn),
    .dataValidIn      (dataValidIn),
    .endTransactionIn (endTransactionIn),
    .busErrorIn       (busErrorIn),
    .addressDataOut   (addressDataOut),
    .dataValidOut     (dataValidOut),
    .endTransactionOut(endTransactionOut),
    .busErrorOut      (busErrorOut)
  );

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBus(input string tag, input bit expValid, input logic [31:0] expData,
                          input bit expEnd, input bit expErr);
    checkOutput(tag, {29'd0, dataValidOut, endTransactionOut, busErrorOut, addressDataOut},
                     {29'd0, expValid, expEnd, expErr, expData});
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    beginTransactionIn = 1'b0;
    addressDataIn      = 32'd0;
    byteEnablesIn      = 4'd0;
    burstSizeIn        = 8'd0;
    readNotWriteIn     = 1'b0;
    dataValidIn        = 1'b0;
    endTransactionIn   = 1'b0;
    busErrorIn         = 1'b0;
  endtask

  task automatic modelWrite(input int idx, input logic [31:0] data, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  // One master transaction starting in the current (idle) cycle; returns in the first
  // cycle where the slave is idle again. Outputs are checked in every cycle.
  task automatic applyStimulus(input logic [31:0] addr, input int burst, input bit rnw,
                               input int extraBeats, input bit lastWithEnd, input int abortAt,
                               input bit randomGaps);
    int      n;
    longint  off;
    bit      sel;
    bit      over;
    int      word;
    int      sent;
    int      cyc;
    bit      v;
    bit      e;
    logic [31:0] d;
    n    = burst + 1;
    off  = longint'(addr) - longint'(BASE);
    sel  = (off >= 0) && (off < 4 * WORDS);
    word = sel ? int'(off / 4) : 0;
    over = sel && (word + burst >= WORDS);
    rdWords.delete();

    checkBus("idle at begin", 1'b0, 32'd0, 1'b0, 1'b0);
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    burstSizeIn        = 8'(burst);
    readNotWriteIn     = rnw;
    nextCycle();
    idleInputs();
    if (!sel) return;

    if (over) begin
      checkBus("range error strobe", 1'b0, 32'd0, 1'b1, 1'b1);
      nextCycle();
      return;
    end

    if (rnw) begin
      for (int k = 1; k <= n + 2; k++) begin
        v = (k >= 2) && (k <= n + 1);
        e = (k == n + 2);
        d = v ? model[word + k - 2] : 32'd0;
        if (v) rdWords.push_back(addressDataOut);
        checkBus($sformatf("read k=%0d", k), v, d, e, 1'b0);
        if (k == abortAt) begin
          endTransactionIn = 1'b1;
          nextCycle();
          idleInputs();
          return;
        end
        nextCycle();
      end
    end else begin
      sent = 0;
      cyc  = 0;
      while (sent < n + extraBeats && cyc < 4000) begin
        v = randomGaps ? ($urandom_range(3) != 0) : 1'b1;
        checkBus($sformatf("write cyc=%0d", cyc), 1'b0, 32'd0, 1'b0, 1'b0);
        dataValidIn = v;
        if (v) begin
          addressDataIn = (sent < n) ? wrData[sent] : $urandom;
          byteEnablesIn = (sent < n) ? wrBe[sent] : 4'hF;
          if (sent < n) modelWrite(word + sent, addressDataIn, byteEnablesIn);
          sent++;
          if (lastWithEnd && sent == n + extraBeats) endTransactionIn = 1'b1;
        end
        nextCycle();
        idleInputs();
        cyc++;
      end
      if (!lastWithEnd) begin
        checkBus("write end", 1'b0, 32'd0, 1'b0, 1'b0);
        endTransactionIn = 1'b1;
        nextCycle();
        idleInputs();
      end
    end
  endtask

  initial begin
    idleInputs();
    reset = 1'b1;
    #1;
    checkBus("reset outputs", 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) nextCycle();
    reset = 1'b0;
    checkBus("after reset release", 1'b0, 32'd0, 1'b0, 1'b0);

    // Fill the whole memory with 256-word bursts so every word has a known value.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin
        wrData[i] = $urandom;
        wrBe[i]   = 4'hF;
      end
      applyStimulus(BASE + 32'(blk * 1024), 255, 1'b0, 0, 1'b1, -1, 1'b0);
    end
    applyStimulus(BASE + 32'd2048, 255, 1'b1, 0, 1'b0, -1, 1'b0);
    checkOutput("256-word read length", 64'(rdWords.size()), 64'd256);

    $display("[TB] write then read 0x5000_0010");
    for (int i = 0; i < 4; i++) begin
      wrData[i] = 32'hA0 + 32'(i);
      wrBe[i]   = 4'hF;
    end
    applyStimulus(BASE + 32'h10, 3, 1'b0, 0, 1'b1, -1, 1'b0);
    applyStimulus(BASE + 32'h10, 3, 1'b1, 0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("readback word %0d", i), 64'(rdWords[i]), 64'(32'hA0 + 32'(i)));
    end

    $display("[TB] byte enables");
    wrData[0] = 32'hFFFF_FFFF;
    wrBe[0]   = 4'hF;
    applyStimulus(BASE + 32'd400, 0, 1'b0, 0, 1'b1, -1, 1'b0);
    wrData[0] = 32'h1234_5678;
    wrBe[0]   = 4'b0101;
    applyStimulus(BASE + 32'd400, 0, 1'b0, 0, 1'b0, -1, 1'b0);
    applyStimulus(BASE + 32'd400, 0, 1'b1, 0, 1'b0, -1, 1'b0);
    checkOutput("byte-enable merge", 64'(rdWords[0]), 64'h0000_0000_FF34_FF78);

    $display("[TB] address range");
    applyStimulus(32'h4FFF_FFFC, 0, 1'b1, 0, 1'b0, -1, 1'b0);
    applyStimulus(BASE + 32'(4 * WORDS), 0, 1'b1, 0, 1'b0, -1, 1'b0);
    applyStimulus(BASE + 32'(4 * 1022), 3, 1'b0, 0, 1'b1, -1, 1'b0);
    applyStimulus(BASE + 32'(4 * 1022), 1, 1'b1, 0, 1'b0, -1, 1'b0);

    $display("[TB] abort during 2nd word of 8-word read");
    applyStimulus(BASE + 32'(4 * 200), 7, 1'b1, 0, 1'b0, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkBus($sformatf("after abort %0d", i), 1'b0, 32'd0, 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(BASE + 32'(4 * 200), 1, 1'b1, 0, 1'b0, -1, 1'b0);

    $display("[TB] reset mid-write");
    beginTransactionIn = 1'b1;
    addressDataIn      = BASE + 32'(4 * 300);
    burstSizeIn        = 8'd3;
    readNotWriteIn     = 1'b0;
    nextCycle();
    idleInputs();
    for (int i = 0; i < 2; i++) begin
      dataValidIn   = 1'b1;
      addressDataIn = 32'hC0DE_0000 + 32'(i);
      byteEnablesIn = 4'hF;
      modelWrite(300 + i, addressDataIn, 4'hF);
      nextCycle();
    end
    addressDataIn = 32'hDEAD_BEEF;
    #2;
    reset = 1'b1;
    #1;
    checkBus("reset mid-write", 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) nextCycle();
    reset = 1'b0;
    idleInputs();
    applyStimulus(BASE + 32'(4 * 300), 3, 1'b1, 0, 1'b0, -1, 1'b0);

    $display("[TB] reset mid-read");
    beginTransactionIn = 1'b1;
    addressDataIn      = BASE + 32'(4 * 500);
    burstSizeIn        = 8'd7;
    readNotWriteIn     = 1'b1;
    nextCycle();
    idleInputs();
    nextCycle();
    checkBus("read before reset", 1'b1, model[500], 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkBus("reset mid-read", 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) nextCycle();
    reset = 1'b0;
    checkBus("idle after reset", 1'b0, 32'd0, 1'b0, 1'b0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 50; t++) begin
      int          kind;
      int          word;
      int          burst;
      int          abortAt;
      bit          rnw;
      logic [31:0] addr;
      kind  = int'($urandom_range(9));
      rnw   = 1'($urandom_range(1));
      burst = int'($urandom_range(15));
      word  = int'($urandom_range(WORDS - 1));
      if (kind == 1) begin
        word  = int'($urandom_range(1023, 1000));
        burst = int'($urandom_range(40));
      end
      addr = BASE + 32'(word * 4) + 32'($urandom_range(3));
      if (kind == 0) begin
        addr = ($urandom_range(1) == 1) ? BASE - 32'(4 * $urandom_range(64, 1))
                                        : BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(64));
      end
      for (int i = 0; i <= burst; i++) begin
        wrData[i] = $urandom;
        wrBe[i]   = 4'($urandom_range(15));
      end
      abortAt = (rnw && $urandom_range(3) == 0) ? int'($urandom_range(burst + 2, 1)) : -1;
      applyStimulus(addr, burst, rnw, int'($urandom_range(2)), 1'($urandom_range(1)), abortAt,
                    1'($urandom_range(1)));
    end
    checkBus("final idle", 1'b0, 32'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
